gpio_in_ctrl: RTL and testbench



---
 rtl/gpio_in_ctrl_if.sv | 11 +
 rtl/gpio_in_ctrl.sv | 137 +++++++++++++
 tb/tb_gpio_in_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_in_ctrl_if.sv
// CPU-side register bus for gpio_in_ctrl: word address, write strobe/data,
// and combinational read data.
interface gpio_in_ctrl_if;
    logic [2:0]  addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;

    modport master (output addr, output we, output wd, input rd);
    modport slave  (input addr, input we, input wd, output rd);
endinterface

// File: rtl/gpio_in_ctrl.sv
// Bus-attached DIP-switch and user-key input block: 2-flop sync, per-key
// debounce, rise/fall edge capture into W1C pending bits, maskable irq.
module gpio_in_ctrl #(
    parameter int unsigned SW_BYTES        = 8,
    parameter int unsigned KEY_W           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 25000,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1,
    parameter bit          SW_ACTIVE_LOW   = 1'b1
) (
    input  logic                  clk,
    input  logic                  sys_rstn,
    gpio_in_ctrl_if.slave         bus,
    input  logic [8*SW_BYTES-1:0] sw_in,
    input  logic [KEY_W-1:0]      key_in,
    output logic                  irq
);

    localparam int unsigned SwW  = 8 * SW_BYTES;
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] AddrSwLo  = 3'd0;
    localparam logic [2:0] AddrSwHi  = 3'd1;
    localparam logic [2:0] AddrKey   = 3'd2;
    localparam logic [2:0] AddrImask = 3'd3;
    localparam logic [2:0] AddrIpend = 3'd4;
    localparam logic [2:0] AddrIcfg  = 3'd5;

    logic [SwW-1:0]   sw_s1_q, sw_s2_q, sw_synced;
    logic [KEY_W-1:0] key_s1_q, key_s2_q, key_synced;
    logic [KEY_W-1:0] stable_q, stable_d, stable_dly_q;
    logic [CntW-1:0]  cnt_q [KEY_W];
    logic [CntW-1:0]  cnt_d [KEY_W];
    logic [KEY_W-1:0] imask_q, imask_d;
    logic [KEY_W-1:0] rise_en_q, rise_en_d;
    logic [KEY_W-1:0] fall_en_q, fall_en_d;
    logic [KEY_W-1:0] ipend_q, ipend_d;
    logic [KEY_W-1:0] w1c, ev_set;
    logic             irq_q, irq_d;
    logic [63:0]      sw_all;
    logic             unused_wd;

    // Inversion sits after the second flop so reset (flops at 0) is well defined.
    assign sw_synced  = SW_ACTIVE_LOW  ? ~sw_s2_q  : sw_s2_q;
    assign key_synced = KEY_ACTIVE_LOW ? ~key_s2_q : key_s2_q;
    assign sw_all     = 64'(sw_synced);
    assign unused_wd  = ^bus.wd;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < int'(KEY_W); i++) begin
            if (key_synced[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                cnt_d[i]    = '0;
                stable_d[i] = ~stable_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end
        end
    end

    assign ev_set = (stable_q & ~stable_dly_q & rise_en_q)
                  | (~stable_q & stable_dly_q & fall_en_q);

    always_comb begin
        imask_d   = imask_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c       = '0;
        if (bus.we) begin
            case (bus.addr)
                AddrImask: imask_d = bus.wd[KEY_W-1:0];
                AddrIpend: w1c     = bus.wd[KEY_W-1:0];
                AddrIcfg: begin
                    rise_en_d = bus.wd[KEY_W-1:0];
                    fall_en_d = bus.wd[16 +: KEY_W];
                end
                default: ;
            endcase
        end
    end

    // New events override a same-cycle clear.
    assign ipend_d = (ipend_q & ~w1c) | ev_set;
    assign irq_d   = |(ipend_q & imask_q);

    always_ff @(posedge clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            sw_s1_q      <= '0;
            sw_s2_q      <= '0;
            key_s1_q     <= '0;
            key_s2_q     <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            for (int i = 0; i < int'(KEY_W); i++) cnt_q[i] <= '0;
            imask_q      <= '0;
            rise_en_q    <= '0;
            fall_en_q    <= '0;
            ipend_q      <= '0;
            irq_q        <= 1'b0;
        end else begin
            sw_s1_q      <= sw_in;
            sw_s2_q      <= sw_s1_q;
            key_s1_q     <= key_in;
            key_s2_q     <= key_s1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
            imask_q      <= imask_d;
            rise_en_q    <= rise_en_d;
            fall_en_q    <= fall_en_d;
            ipend_q      <= ipend_d;
            irq_q        <= irq_d;
        end
    end

    always_comb begin
        bus.rd = '0;
        case (bus.addr)
            AddrSwLo:  bus.rd = sw_all[31:0];
            AddrSwHi:  bus.rd = sw_all[63:32];
            AddrKey:   bus.rd[KEY_W-1:0] = stable_q;
            AddrImask: bus.rd[KEY_W-1:0] = imask_q;
            AddrIpend: bus.rd[KEY_W-1:0] = ipend_q;
            AddrIcfg: begin
                bus.rd[KEY_W-1:0]  = rise_en_q;
                bus.rd[16 +: KEY_W] = fall_en_q;
            end
            default:   bus.rd = '0;
        endcase
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_gpio_in_ctrl.sv
// Directed bench for gpio_in_ctrl with DEBOUNCE_CYCLES=4: register-map table
// plus hand-timed sequences for debounce, edges, W1C race and async reset.
module tb_gpio_in_ctrl;

    logic        clk = 1'b0;
    logic        sys_rstn;
    logic [63:0] sw_in;
    logic [7:0]  key_in;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gpio_in_ctrl_if bus ();

    gpio_in_ctrl #(
        .SW_BYTES        (8),
        .KEY_W           (8),
        .DEBOUNCE_CYCLES (4),
        .KEY_ACTIVE_LOW  (1'b1),
        .SW_ACTIVE_LOW   (1'b1)
    ) dut (
        .clk      (clk),
        .sys_rstn (sys_rstn),
        .bus      (bus),
        .sw_in    (sw_in),
        .key_in   (key_in),
        .irq      (irq)
    );

    typedef struct {
        logic [2:0]  addr;
        logic        do_wr;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Advance n rising edges and park on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reg(input string name, input logic [2:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        check(name, bus.rd, exp);
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        bus.addr = a;
        bus.wd   = d;
        bus.we   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.we   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;

        vecs[0]  = '{3'd0, 1'b0, 32'h0,         32'h0000_00A5};
        vecs[1]  = '{3'd1, 1'b0, 32'h0,         32'h0};
        vecs[2]  = '{3'd2, 1'b0, 32'h0,         32'h0};
        vecs[3]  = '{3'd3, 1'b0, 32'h0,         32'h0};
        vecs[4]  = '{3'd4, 1'b0, 32'h0,         32'h0};
        vecs[5]  = '{3'd5, 1'b0, 32'h0,         32'h0};
        vecs[6]  = '{3'd6, 1'b0, 32'h0,         32'h0};
        vecs[7]  = '{3'd7, 1'b0, 32'h0,         32'h0};
        vecs[8]  = '{3'd3, 1'b1, 32'hFFFF_FFFF, 32'h0000_00FF};
        vecs[9]  = '{3'd5, 1'b1, 32'hFFFF_FFFF, 32'h00FF_00FF};
        vecs[10] = '{3'd6, 1'b1, 32'h0000_FFFF, 32'h0};
        vecs[11] = '{3'd0, 1'b1, 32'h0000_1234, 32'h0000_00A5};
        vecs[12] = '{3'd1, 1'b1, 32'h0000_0001, 32'h0};
        vecs[13] = '{3'd2, 1'b1, 32'h0000_00FF, 32'h0};
        vecs[14] = '{3'd4, 1'b1, 32'hFFFF_FFFF, 32'h0};
        vecs[15] = '{3'd3, 1'b1, 32'h0,         32'h0};
        vecs[16] = '{3'd5, 1'b1, 32'h0,         32'h0};

        sys_rstn = 1'b0;
        bus.addr = 3'd0;
        bus.we   = 1'b0;
        bus.wd   = 32'h0;
        sw_in    = 64'hFFFF_FFFF_FFFF_FF5A;
        key_in   = 8'hFF;

        repeat (3) @(negedge clk);
        chk_reg("reset_key", 3'd2, 32'h0);
        check("reset_irq", {31'd0, irq}, 32'h0);
        @(negedge clk);
        sys_rstn = 1'b1;
        step(3);
        check("post_reset_irq", {31'd0, irq}, 32'h0);

        for (int i = 0; i < 17; i++) begin
            if (vecs[i].do_wr) wr_reg(vecs[i].addr, vecs[i].wd);
            chk_reg($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
        end

        sw_in = 64'h0123_4567_89AB_CDEF;
        step(3);
        chk_reg("sw_lo_pattern", 3'd0, 32'h7654_3210);
        chk_reg("sw_hi_pattern", 3'd1, 32'hFEDC_BA98);

        // Rise: press before edge k, stable after k+5, IPEND after k+6, irq after k+7.
        wr_reg(3'd5, 32'h1);
        wr_reg(3'd3, 32'h1);
        key_in[0] = 1'b0;
        step(5);
        chk_reg("rise_key_k4", 3'd2, 32'h0);
        step(1);
        chk_reg("rise_key_k5", 3'd2, 32'h1);
        chk_reg("rise_ipend_k5", 3'd4, 32'h0);
        step(1);
        chk_reg("rise_ipend_k6", 3'd4, 32'h1);
        check("rise_irq_k6", {31'd0, irq}, 32'h0);
        step(1);
        check("rise_irq_k7", {31'd0, irq}, 32'h1);
        wr_reg(3'd4, 32'h1);
        key_in[0] = 1'b1;
        step(10);
        chk_reg("release_key", 3'd2, 32'h0);
        chk_reg("rise_only_no_fall", 3'd4, 32'h0);
        check("rise_only_irq", {31'd0, irq}, 32'h0);

        // Three-cycle glitch must never reach the stable state.
        key_in[0] = 1'b0;
        repeat (3) @(negedge clk);
        key_in[0] = 1'b1;
        seen = 1'b0;
        for (int j = 0; j < 12; j++) begin
            step(1);
            bus.addr = 3'd2;
            #1;
            seen = seen | (|bus.rd) | irq;
        end
        check("glitch_sticky", {31'd0, seen}, 32'h0);
        chk_reg("glitch_ipend", 3'd4, 32'h0);

        // Fall-only enable.
        wr_reg(3'd5, 32'h0001_0000);
        key_in[0] = 1'b0;
        step(10);
        chk_reg("fall_press_key", 3'd2, 32'h1);
        chk_reg("fall_no_set_on_press", 3'd4, 32'h0);
        key_in[0] = 1'b1;
        step(10);
        chk_reg("fall_release_key", 3'd2, 32'h0);
        chk_reg("fall_ipend", 3'd4, 32'h1);
        check("fall_irq", {31'd0, irq}, 32'h1);
        wr_reg(3'd3, 32'h0);
        check("imask_clr_lag", {31'd0, irq}, 32'h1);
        step(1);
        check("imask_clr_irq", {31'd0, irq}, 32'h0);
        chk_reg("imask_clr_ipend", 3'd4, 32'h1);
        wr_reg(3'd3, 32'h1);
        check("imask_set_lag", {31'd0, irq}, 32'h0);
        step(1);
        check("imask_set_irq", {31'd0, irq}, 32'h1);

        // W1C landing on the same edge as a new rise.
        wr_reg(3'd5, 32'h1);
        wr_reg(3'd4, 32'h1);
        chk_reg("w1c_pre_clear", 3'd4, 32'h0);
        key_in[0] = 1'b0;
        step(6);
        wr_reg(3'd4, 32'h1);
        chk_reg("w1c_race_set_wins", 3'd4, 32'h1);
        step(2);
        wr_reg(3'd4, 32'h1);
        chk_reg("w1c_quiet_clear", 3'd4, 32'h0);
        check("w1c_irq_lag", {31'd0, irq}, 32'h1);
        step(1);
        check("w1c_irq_clear", {31'd0, irq}, 32'h0);

        // Async reset mid-debounce with IPEND=0x3.
        key_in[0] = 1'b1;
        step(10);
        wr_reg(3'd4, 32'hFF);
        wr_reg(3'd5, 32'h3);
        wr_reg(3'd3, 32'h3);
        key_in[1:0] = 2'b00;
        step(10);
        chk_reg("pre_rst_ipend", 3'd4, 32'h3);
        check("pre_rst_irq", {31'd0, irq}, 32'h1);
        key_in[2] = 1'b0;
        step(4);
        sys_rstn = 1'b0;
        #1;
        check("rst_irq", {31'd0, irq}, 32'h0);
        chk_reg("rst_ipend", 3'd4, 32'h0);
        chk_reg("rst_key", 3'd2, 32'h0);
        chk_reg("rst_imask", 3'd3, 32'h0);
        chk_reg("rst_icfg", 3'd5, 32'h0);
        @(negedge clk);
        sys_rstn = 1'b1;
        wr_reg(3'd5, 32'h4);
        wr_reg(3'd3, 32'h4);
        step(10);
        chk_reg("post_rst_key", 3'd2, 32'h7);
        chk_reg("post_rst_event", 3'd4, 32'h4);
        check("post_rst_irq", {31'd0, irq}, 32'h1);
        wr_reg(3'd4, 32'h4);
        step(10);
        chk_reg("post_rst_single_event", 3'd4, 32'h0);
        check("post_rst_irq_clear", {31'd0, irq}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
